// File: rtl/fft_frame_sequencer.sv
// fft_frame_sequencer: runs a multi-frame FFT job (config once, then load/drain per frame)
module fft_frame_sequencer #(
    parameter int TRANSFORM_LENGTH = 1024,
    parameter int DATA_W           = 16,
    parameter int CFG_W            = 21
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              start,
    input  logic              abort,
    input  logic [7:0]        frame_count,
    input  logic [CFG_W-1:0]  cfg_word,
    input  logic [DATA_W-1:0] s_tdata,
    input  logic              s_tvalid,
    output logic              s_tready,
    output logic [CFG_W-1:0]  fft_cfg_tdata,
    output logic              fft_cfg_tvalid,
    input  logic              fft_cfg_tready,
    output logic [DATA_W-1:0] fft_din_tdata,
    output logic              fft_din_tvalid,
    input  logic              fft_din_tready,
    input  logic [DATA_W-1:0] fft_dout_tdata,
    input  logic              fft_dout_tvalid,
    output logic              fft_dout_tready,
    input  logic              fft_dout_tlast,
    output logic [DATA_W-1:0] m_tdata,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic              m_tlast,
    output logic              busy,
    output logic              done,
    output logic [7:0]        frame_idx,
    output logic              err_tlast_early,
    output logic              err_tlast_missing
);
    localparam int CNT_W = $clog2(TRANSFORM_LENGTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TRANSFORM_LENGTH - 1);

    typedef enum logic [2:0] {IDLE, CONFIG, LOAD, DRAIN, DONE} state_t;

    state_t             state;
    logic [CNT_W-1:0]   in_cnt;
    logic [CNT_W-1:0]   out_cnt;
    logic [CFG_W-1:0]   cfg_q;
    logic [7:0]         count_q;
    logic               load;
    logic               drain;
    logic               din_fire;
    logic               dout_fire;

    // Data paths are pure pass-through; only the registered phase flags gate them.
    assign fft_cfg_tdata   = cfg_q;
    assign fft_din_tdata   = s_tdata;
    assign fft_din_tvalid  = load && s_tvalid;
    assign s_tready        = load && fft_din_tready;
    assign m_tdata         = fft_dout_tdata;
    assign m_tvalid        = drain && fft_dout_tvalid;
    assign fft_dout_tready = drain && m_tready;
    assign m_tlast         = drain && out_cnt == LAST;
    assign din_fire        = load && s_tvalid && fft_din_tready;
    assign dout_fire       = drain && fft_dout_tvalid && m_tready;

    always_ff @(posedge aclk) begin
        if (areset) begin
            state             <= IDLE;
            in_cnt            <= '0;
            out_cnt           <= '0;
            frame_idx         <= '0;
            cfg_q             <= '0;
            count_q           <= '0;
            err_tlast_early   <= 1'b0;
            err_tlast_missing <= 1'b0;
            busy              <= 1'b0;
            done              <= 1'b0;
            fft_cfg_tvalid    <= 1'b0;
            load              <= 1'b0;
            drain             <= 1'b0;
        end else if (abort) begin
            state          <= IDLE;
            in_cnt         <= '0;
            out_cnt        <= '0;
            frame_idx      <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            fft_cfg_tvalid <= 1'b0;
            load           <= 1'b0;
            drain          <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && frame_count != 8'd0) begin
                        state             <= CONFIG;
                        cfg_q             <= cfg_word;
                        count_q           <= frame_count;
                        frame_idx         <= '0;
                        err_tlast_early   <= 1'b0;
                        err_tlast_missing <= 1'b0;
                        busy              <= 1'b1;
                        fft_cfg_tvalid    <= 1'b1;
                    end
                end
                CONFIG: begin
                    if (fft_cfg_tready) begin
                        state          <= LOAD;
                        fft_cfg_tvalid <= 1'b0;
                        load           <= 1'b1;
                    end
                end
                LOAD: begin
                    if (din_fire) begin
                        in_cnt <= (in_cnt == LAST) ? '0 : in_cnt + 1'b1;
                        if (in_cnt == LAST) begin
                            state <= DRAIN;
                            load  <= 1'b0;
                            drain <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (dout_fire) begin
                        if (fft_dout_tlast && out_cnt != LAST)
                            err_tlast_early <= 1'b1;
                        if (!fft_dout_tlast && out_cnt == LAST)
                            err_tlast_missing <= 1'b1;
                        out_cnt <= (out_cnt == LAST) ? '0 : out_cnt + 1'b1;
                        if (out_cnt == LAST) begin
                            frame_idx <= frame_idx + 8'd1;
                            drain     <= 1'b0;
                            // Widened compare so frame_count=255 cannot wrap.
                            if (({1'b0, frame_idx} + 9'd1) < {1'b0, count_q}) begin
                                state <= LOAD;
                                load  <= 1'b1;
                            end else begin
                                state <= DONE;
                                done  <= 1'b1;
                            end
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fft_frame_sequencer.sv
// tb_fft_frame_sequencer: directed runs with randomized handshakes against a stream-level model
module tb_fft_frame_sequencer;
    localparam int TL = 8;
    localparam int DW = 16;
    localparam int CW = 7;

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
        logic [7:0]    f;
    } beat_t;

    logic          aclk = 1'b0;
    logic          areset = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [7:0]    frame_count = '0;
    logic [CW-1:0] cfg_word = '0;
    logic [DW-1:0] s_tdata = '0;
    logic          s_tvalid = 1'b0;
    logic          s_tready;
    logic [CW-1:0] fft_cfg_tdata;
    logic          fft_cfg_tvalid;
    logic          fft_cfg_tready = 1'b1;
    logic [DW-1:0] fft_din_tdata;
    logic          fft_din_tvalid;
    logic          fft_din_tready = 1'b1;
    logic [DW-1:0] fft_dout_tdata = '0;
    logic          fft_dout_tvalid = 1'b0;
    logic          fft_dout_tready;
    logic          fft_dout_tlast = 1'b0;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tready = 1'b1;
    logic          m_tlast;
    logic          busy;
    logic          done;
    logic [7:0]    frame_idx;
    logic          err_tlast_early;
    logic          err_tlast_missing;

    int src_gap = 0, din_gap = 0, dout_gap = 0, cfg_gap = 0, m_mode = 0;
    bit src_on = 1'b0, src_rand = 1'b0, s_hs = 1'b0;
    int inj_early_fr = -1, inj_early_b = -1, inj_miss_fr = -1;
    logic [DW-1:0] fft_q[$];
    logic [DW-1:0] s_log[$];
    logic [DW-1:0] din_log[$];
    logic [CW-1:0] cfg_log[$];
    beat_t m_obs[$];
    beat_t mb;
    int n_done = 0, fb = 0, ffr = 0;
    int n_chk = 0, n_fail = 0;

    fft_frame_sequencer #(.TRANSFORM_LENGTH(TL), .DATA_W(DW), .CFG_W(CW)) dut (
        .aclk(aclk), .areset(areset), .start(start), .abort(abort),
        .frame_count(frame_count), .cfg_word(cfg_word),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .fft_cfg_tdata(fft_cfg_tdata), .fft_cfg_tvalid(fft_cfg_tvalid), .fft_cfg_tready(fft_cfg_tready),
        .fft_din_tdata(fft_din_tdata), .fft_din_tvalid(fft_din_tvalid), .fft_din_tready(fft_din_tready),
        .fft_dout_tdata(fft_dout_tdata), .fft_dout_tvalid(fft_dout_tvalid),
        .fft_dout_tready(fft_dout_tready), .fft_dout_tlast(fft_dout_tlast),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
        .busy(busy), .done(done), .frame_idx(frame_idx),
        .err_tlast_early(err_tlast_early), .err_tlast_missing(err_tlast_missing)
    );

    always #5 aclk = ~aclk;

    // Stand-in FFT: output sample k of a frame is a fixed scramble of input sample k.
    function automatic logic [DW-1:0] xf(input logic [DW-1:0] x);
        return {x[7:0], x[15:8]} ^ 16'h5A3C;
    endfunction

    always @(negedge aclk) begin
        s_hs = s_tvalid && s_tready;
        if (s_hs) s_log.push_back(s_tdata);
        if (fft_cfg_tvalid && fft_cfg_tready) cfg_log.push_back(fft_cfg_tdata);
        if (fft_din_tvalid && fft_din_tready) begin
            din_log.push_back(fft_din_tdata);
            fft_q.push_back(fft_din_tdata);
        end
        if (fft_dout_tvalid && fft_dout_tready) begin
            if (fft_q.size() > 0) void'(fft_q.pop_front());
            fb = (fb == TL - 1) ? 0 : fb + 1;
            if (fb == 0) ffr++;
        end
        if (m_tvalid && m_tready) begin
            mb.d = m_tdata;
            mb.l = m_tlast;
            mb.f = frame_idx;
            m_obs.push_back(mb);
        end
        if (done) n_done++;
    end

    always @(posedge aclk) begin
        #1;
        if (s_hs || !s_tvalid) begin
            if (s_hs) s_tdata = src_rand ? DW'($urandom) : s_tdata + 1'b1;
            s_tvalid = src_on && ($urandom_range(99) >= src_gap);
        end
        fft_cfg_tready  = $urandom_range(99) >= cfg_gap;
        fft_din_tready  = $urandom_range(99) >= din_gap;
        m_tready        = (m_mode == 0) ? 1'b1 : ~m_tready;
        fft_dout_tvalid = (fft_q.size() > 0) && ($urandom_range(99) >= dout_gap);
        fft_dout_tdata  = (fft_q.size() > 0) ? xf(fft_q[0]) : '0;
        fft_dout_tlast  = (fb == TL - 1 && ffr != inj_miss_fr) || (fb == inj_early_b && ffr == inj_early_fr);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_s_tready"}, s_tready, 0);
        chk({tag, "_din_tvalid"}, fft_din_tvalid, 0);
        chk({tag, "_cfg_tvalid"}, fft_cfg_tvalid, 0);
        chk({tag, "_m_tvalid"}, m_tvalid, 0);
        chk({tag, "_dout_tready"}, fft_dout_tready, 0);
        chk({tag, "_frame_idx"}, frame_idx, 0);
    endtask

    task automatic clear_model();
        s_log.delete(); din_log.delete(); fft_q.delete(); cfg_log.delete(); m_obs.delete();
        n_done = 0; fb = 0; ffr = 0;
    endtask

    task automatic start_run(input logic [7:0] fc, input logic [CW-1:0] cw);
        @(posedge aclk); #1;
        start = 1'b1; frame_count = fc; cfg_word = cw;
        @(posedge aclk); #1;
        start = 1'b0; frame_count = 8'($urandom); cfg_word = CW'($urandom);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int t = 0;
        while (!done && t < budget) begin
            @(negedge aclk);
            t++;
        end
        chk({tag, "_done_seen"}, done, 1);
        @(negedge aclk);
        chk({tag, "_busy_after_done"}, busy, 0);
    endtask

    task automatic wait_m(input string tag, input int n, input int budget);
        int t = 0;
        while (m_obs.size() < n && t < budget) begin
            @(negedge aclk);
            t++;
        end
        chk({tag, "_m_progress"}, m_obs.size() >= n, 1);
    endtask

    task automatic check_run(input string tag, input int frames, input logic [CW-1:0] cw);
        repeat (2) @(negedge aclk);
        chk({tag, "_cfg_beats"}, cfg_log.size(), 1);
        if (cfg_log.size() > 0) chk({tag, "_cfg_word"}, cfg_log[0], cw);
        chk({tag, "_done_cycles"}, n_done, 1);
        chk({tag, "_frame_idx_end"}, frame_idx, frames);
        chk({tag, "_m_beats"}, m_obs.size(), TL * frames);
        chk({tag, "_s_beats"}, s_log.size(), TL * frames);
        foreach (m_obs[i]) begin
            if (i < s_log.size()) chk($sformatf("%s_m_tdata%0d", tag, i), m_obs[i].d, xf(s_log[i]));
            chk($sformatf("%s_m_tlast%0d", tag, i), m_obs[i].l, (i % TL) == TL - 1);
            chk($sformatf("%s_frame_idx%0d", tag, i), m_obs[i].f, i / TL);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [CW-1:0] cw;
        int t;
        repeat (3) @(posedge aclk);
        #1 areset = 1'b0;
        @(negedge aclk);
        chk_idle("reset");
        chk("reset_err_early", err_tlast_early, 0);
        chk("reset_err_missing", err_tlast_missing, 0);

        // Single frame, always ready, data 1..8
        clear_model();
        s_tdata = 16'd1;
        src_on = 1'b1;
        start_run(8'd1, 7'h55);
        wait_done("t1", 100);
        check_run("t1", 1, 7'h55);
        chk("t1_din_n", din_log.size(), TL);
        foreach (din_log[i]) chk($sformatf("t1_din%0d", i), din_log[i], i + 1);

        // Two frames under backpressure everywhere
        src_rand = 1'b1; src_gap = 40; din_gap = 30; dout_gap = 30; cfg_gap = 50; m_mode = 1;
        clear_model();
        cw = CW'($urandom);
        start_run(8'd2, cw);
        wait_done("t2", 600);
        check_run("t2", 2, cw);

        // Early tlast in frame 0, missing tlast in frame 1
        inj_early_fr = 0; inj_early_b = 3; inj_miss_fr = 1;
        clear_model();
        cw = CW'($urandom);
        start_run(8'd2, cw);
        wait_m("t3", TL, 400);
        chk("t3_early_after_f0", err_tlast_early, 1);
        chk("t3_missing_after_f0", err_tlast_missing, 0);
        wait_done("t3", 400);
        check_run("t3", 2, cw);
        chk("t3_err_early", err_tlast_early, 1);
        chk("t3_err_missing", err_tlast_missing, 1);
        inj_early_fr = -1; inj_early_b = -1; inj_miss_fr = -1;

        // frame_count=0 is ignored, errors stay sticky
        clear_model();
        start_run(8'd0, 7'h33);
        repeat (3) @(negedge aclk);
        chk("t_fc0_busy", busy, 0);
        chk("t_fc0_cfg", cfg_log.size(), 0);
        chk("t_fc0_err_early", err_tlast_early, 1);
        chk("t_fc0_err_missing", err_tlast_missing, 1);

        // abort and start together: abort wins
        @(posedge aclk); #1;
        start = 1'b1; abort = 1'b1; frame_count = 8'd1;
        @(posedge aclk); #1;
        start = 1'b0; abort = 1'b0;
        repeat (3) @(negedge aclk);
        chk("t_abst_busy", busy, 0);
        chk("t_abst_cfg", cfg_log.size(), 0);

        // Accepted start clears errors; start during DRAIN is ignored
        clear_model();
        start_run(8'd1, 7'h2A);
        @(negedge aclk);
        chk("t4_busy", busy, 1);
        chk("t4_err_early_clr", err_tlast_early, 0);
        chk("t4_err_missing_clr", err_tlast_missing, 0);
        wait_m("t4", 2, 300);
        @(posedge aclk); #1;
        start = 1'b1; frame_count = 8'd3; cfg_word = 7'h11;
        @(posedge aclk); #1;
        start = 1'b0;
        wait_done("t4", 300);
        check_run("t4", 1, 7'h2A);

        // Abort mid-LOAD, then a clean restart
        din_gap = 0;
        clear_model();
        start_run(8'd1, CW'($urandom));
        t = 0;
        while (s_log.size() < 5 && t < 300) begin
            @(negedge aclk);
            t++;
        end
        chk("t5_five_loaded", s_log.size() >= 5, 1);
        @(posedge aclk); #1 abort = 1'b1;
        @(posedge aclk); #1 abort = 1'b0;
        @(negedge aclk);
        chk_idle("t5_abort");
        repeat (4) @(negedge aclk);
        chk("t5_no_done", n_done, 0);
        clear_model();
        start_run(8'd1, 7'h0F);
        wait_done("t5", 300);
        check_run("t5", 1, 7'h0F);

        // Reset held 3 cycles mid-DRAIN
        inj_early_fr = 0; inj_early_b = 1;
        clear_model();
        start_run(8'd2, CW'($urandom));
        wait_m("t6", 3, 400);
        chk("t6_err_early_pre", err_tlast_early, 1);
        @(posedge aclk); #1 areset = 1'b1;
        repeat (3) @(posedge aclk);
        #1 areset = 1'b0;
        @(negedge aclk);
        chk_idle("t6_reset");
        chk("t6_err_early", err_tlast_early, 0);
        chk("t6_err_missing", err_tlast_missing, 0);
        repeat (3) @(negedge aclk);
        chk("t6_no_done", n_done, 0);
        inj_early_fr = -1; inj_early_b = -1;

        // Random three-frame run after reset
        din_gap = 25;
        clear_model();
        cw = CW'($urandom);
        start_run(8'd3, cw);
        wait_done("t7", 900);
        check_run("t7", 3, cw);
        chk("t7_err_early", err_tlast_early, 0);
        chk("t7_err_missing", err_tlast_missing, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
